// File: rtl/grf_wb_queue_pkg.sv
// Shared widths and the issue-source encoding for the GRF writeback front end.
// An aux queue entry holds {valid, addr, data, pc}.
package grf_wb_queue_pkg;
  localparam int GRF_ADDR_W = 5;
  localparam int GRF_DATA_W = 32;
  localparam int WBQ_DEPTH  = 4;
  localparam int PC_W       = 32;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_AUX  = 2'd2
  } wbq_src_e;
endpackage

// File: rtl/grf_wb_queue_if.sv
// Bus bundle between the writeback sources, the GRF write port and the hazard unit.
// The slave modport is the queue block; the master modport is whoever drives it.
interface grf_wb_queue_if
  import grf_wb_queue_pkg::*;
#(
  parameter int DEPTH  = WBQ_DEPTH,
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int DATA_W = GRF_DATA_W
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_data;
  logic [PC_W-1:0]   pipe_pc;
  logic              aux_valid;
  logic              aux_ready;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_data;
  logic [PC_W-1:0]   aux_pc;
  logic              grf_we;
  logic [ADDR_W-1:0] grf_addr;
  logic [DATA_W-1:0] grf_data;
  logic [PC_W-1:0]   grf_pc;
  logic [ADDR_W-1:0] hz_addr1;
  logic [ADDR_W-1:0] hz_addr2;
  logic              hz_pending1;
  logic              hz_pending2;
  logic [CNT_W-1:0]  q_count;

  modport master (
    output pipe_we, pipe_addr, pipe_data, pipe_pc,
    output aux_valid, aux_addr, aux_data, aux_pc,
    output hz_addr1, hz_addr2,
    input  aux_ready, grf_we, grf_addr, grf_data, grf_pc,
    input  hz_pending1, hz_pending2, q_count
  );

  modport slave (
    input  pipe_we, pipe_addr, pipe_data, pipe_pc,
    input  aux_valid, aux_addr, aux_data, aux_pc,
    input  hz_addr1, hz_addr2,
    output aux_ready, grf_we, grf_addr, grf_data, grf_pc,
    output hz_pending1, hz_pending2, q_count
  );
endinterface

// File: rtl/grf_wb_queue_fifo.sv
// In-order circular store for aux writebacks with squash-by-address and two
// associative hazard lookups over the valid entries.
module grf_wb_queue_fifo
  import grf_wb_queue_pkg::*;
#(
  parameter int DEPTH  = WBQ_DEPTH,
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int DATA_W = GRF_DATA_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_push,
  input  logic                         i_push_squash,
  input  logic [ADDR_W-1:0]            i_push_addr,
  input  logic [DATA_W-1:0]            i_push_data,
  input  logic [PC_W-1:0]              i_push_pc,
  input  logic                         i_pop,
  input  logic                         i_squash_en,
  input  logic [ADDR_W-1:0]            i_squash_addr,
  input  logic [ADDR_W-1:0]            i_hz_addr1,
  input  logic [ADDR_W-1:0]            i_hz_addr2,
  output logic                         o_head_valid,
  output logic [ADDR_W-1:0]            o_head_addr,
  output logic [DATA_W-1:0]            o_head_data,
  output logic [PC_W-1:0]              o_head_pc,
  output logic [$clog2(DEPTH):0]       o_count,
  output logic                         o_ready,
  output logic                         o_empty,
  output logic                         o_hz_pending1,
  output logic                         o_hz_pending2
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PC_W-1:0]   r_pc   [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  // Valid bits double as occupancy for the hazard lookups, so a pop clears its slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_squash_en && (r_addr[i] == i_squash_addr)) r_valid[i] <= 1'b0;
      end
      if (i_pop) begin
        r_valid[r_rptr] <= 1'b0;
        r_rptr          <= r_rptr + PTR_W'(1);
      end
      if (i_push) begin
        r_valid[r_wptr] <= ~i_push_squash;
        r_wptr          <= r_wptr + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_addr[r_wptr] <= i_push_addr;
      r_data[r_wptr] <= i_push_data;
      r_pc[r_wptr]   <= i_push_pc;
    end
  end

  always_comb begin
    o_hz_pending1 = 1'b0;
    o_hz_pending2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == i_hz_addr1)) o_hz_pending1 = 1'b1;
      if (r_valid[i] && (r_addr[i] == i_hz_addr2)) o_hz_pending2 = 1'b1;
    end
    if (i_hz_addr1 == '0) o_hz_pending1 = 1'b0;
    if (i_hz_addr2 == '0) o_hz_pending2 = 1'b0;
  end

  assign o_head_valid = r_valid[r_rptr];
  assign o_head_addr  = r_addr[r_rptr];
  assign o_head_data  = r_data[r_rptr];
  assign o_head_pc    = r_pc[r_rptr];
  assign o_count      = r_count;
  assign o_ready      = (r_count < CNT_W'(DEPTH));
  assign o_empty      = (r_count == '0);
endmodule

// File: rtl/grf_wb_queue.sv
// Merges the W-stage write and the buffered aux writes onto the single GRF
// write port through one output register; the pipeline write always wins.
module grf_wb_queue
  import grf_wb_queue_pkg::*;
#(
  parameter int DEPTH  = WBQ_DEPTH,
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int DATA_W = GRF_DATA_W
) (
  input logic           clk,
  input logic           reset,
  grf_wb_queue_if.slave bus
);
  logic                  w_pipe_issue;
  logic                  w_push;
  logic                  w_push_squash;
  logic                  w_pop;
  logic                  w_head_valid;
  logic [ADDR_W-1:0]     w_head_addr;
  logic [DATA_W-1:0]     w_head_data;
  logic [PC_W-1:0]       w_head_pc;
  logic [$clog2(DEPTH):0] w_count;
  logic                  w_ready;
  logic                  w_empty;
  wbq_src_e              w_src;

  logic                  r_grf_we;
  logic [ADDR_W-1:0]     r_grf_addr;
  logic [DATA_W-1:0]     r_grf_data;
  logic [PC_W-1:0]       r_grf_pc;

  assign w_pipe_issue = bus.pipe_we && (bus.pipe_addr != '0);
  assign w_pop        = !w_pipe_issue && !w_empty;
  assign w_push       = bus.aux_valid && w_ready;
  // The pipeline write is younger than a same-cycle aux, so that aux is dead on arrival.
  assign w_push_squash = (bus.aux_addr == '0) ||
                         (w_pipe_issue && (bus.aux_addr == bus.pipe_addr));

  grf_wb_queue_fifo #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_squash(w_push_squash),
    .i_push_addr  (bus.aux_addr),
    .i_push_data  (bus.aux_data),
    .i_push_pc    (bus.aux_pc),
    .i_pop        (w_pop),
    .i_squash_en  (w_pipe_issue),
    .i_squash_addr(bus.pipe_addr),
    .i_hz_addr1   (bus.hz_addr1),
    .i_hz_addr2   (bus.hz_addr2),
    .o_head_valid (w_head_valid),
    .o_head_addr  (w_head_addr),
    .o_head_data  (w_head_data),
    .o_head_pc    (w_head_pc),
    .o_count      (w_count),
    .o_ready      (w_ready),
    .o_empty      (w_empty),
    .o_hz_pending1(bus.hz_pending1),
    .o_hz_pending2(bus.hz_pending2)
  );

  always_comb begin
    w_src = SRC_NONE;
    if (w_pipe_issue) w_src = SRC_PIPE;
    else if (w_pop && w_head_valid && (w_head_addr != '0)) w_src = SRC_AUX;
  end

  // A squashed head is still popped; its slot just leaves grf_we low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grf_we   <= 1'b0;
      r_grf_addr <= '0;
      r_grf_data <= '0;
      r_grf_pc   <= '0;
    end else begin
      case (w_src)
        SRC_PIPE: begin
          r_grf_we   <= 1'b1;
          r_grf_addr <= bus.pipe_addr;
          r_grf_data <= bus.pipe_data;
          r_grf_pc   <= bus.pipe_pc;
        end
        SRC_AUX: begin
          r_grf_we   <= 1'b1;
          r_grf_addr <= w_head_addr;
          r_grf_data <= w_head_data;
          r_grf_pc   <= w_head_pc;
        end
        default: r_grf_we <= 1'b0;
      endcase
    end
  end

  assign bus.grf_we    = r_grf_we;
  assign bus.grf_addr  = r_grf_addr;
  assign bus.grf_data  = r_grf_data;
  assign bus.grf_pc    = r_grf_pc;
  assign bus.aux_ready = w_ready;
  assign bus.q_count   = w_count;
endmodule
